// File: rtl/ti_link_pkg.sv
// Shared definitions for the TI link responder: command codes, state
// encodings and small decode helpers.
package ti_link_pkg;

   localparam logic [7:0] CMD_VAR = 8'h06;
   localparam logic [7:0] CMD_XDP = 8'h15;
   localparam logic [7:0] CMD_SKE = 8'h36;
   localparam logic [7:0] CMD_DEL = 8'h88;
   localparam logic [7:0] CMD_REQ = 8'hA2;
   localparam logic [7:0] CMD_RTS = 8'hC9;
   localparam logic [7:0] CMD_ACK = 8'h56;
   localparam logic [7:0] CMD_ERR = 8'h5A;

   typedef enum logic [2:0] {
      S_MID, S_CMD, S_LEN0, S_LEN1, S_DATA, S_CK0, S_CK1, S_REPLY
   } state_t;

   typedef enum logic [1:0] {
      R_IDLE, R_WAIT, R_REQ
   } snd_state_t;

   // Commands that carry a data section followed by a checksum.
   function automatic logic has_data(input logic [7:0] cmd);
      logic r;
      case (cmd)
         CMD_VAR, CMD_XDP, CMD_SKE, CMD_DEL, CMD_REQ, CMD_RTS: r = 1'b1;
         default:                                              r = 1'b0;
      endcase
      return r;
   endfunction

   // Reply packet byte idx: mid, ACK/ERR, then a zero length.
   function automatic logic [7:0] reply_byte(input logic [1:0] idx,
                                             input logic       is_err,
                                             input logic [7:0] mid);
      logic [7:0] r;
      case (idx)
         2'd0:    r = mid;
         2'd1:    r = is_err ? CMD_ERR : CMD_ACK;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ti_reply_sender.sv
// Sends a 4-byte ACK/ERR reply over the four-phase dbus tx handshake.
module ti_reply_sender
   import ti_link_pkg::*;
#(
   parameter logic [7:0] c_REPLYMID = 8'h23
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  logic       i_is_err,
   input  logic       i_txbusy,
   output logic [7:0] o_txdata,
   output logic       o_txenable,
   output logic       o_done
);

   snd_state_t state, state_nxt;
   logic [1:0] idx;
   logic       is_err;

   // Next state: wait for an idle transmitter, request, wait for it to take the byte.
   always_comb begin
      state_nxt = state;
      o_done    = 1'b0;
      case (state)
         R_IDLE: if (i_start)   state_nxt = R_WAIT;
         R_WAIT: if (!i_txbusy) state_nxt = R_REQ;
         R_REQ:  if (i_txbusy) begin
            if (idx == 2'd3) begin
               o_done    = 1'b1;
               state_nxt = R_IDLE;
            end else begin
               state_nxt = R_WAIT;
            end
         end
         default: state_nxt = R_IDLE;
      endcase
   end

   // State, byte index and reply kind.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state  <= R_IDLE;
         idx    <= 2'd0;
         is_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == R_IDLE && i_start) begin
            idx    <= 2'd0;
            is_err <= i_is_err;
         end else if (state == R_REQ && i_txbusy) begin
            idx <= idx + 2'd1;
         end
      end
   end

   assign o_txenable = (state == R_REQ);
   assign o_txdata   = (state == R_REQ) ? reply_byte(idx, is_err, c_REPLYMID) : 8'h00;

endmodule

// File: rtl/ti_link_responder.sv
// TI link packet responder: parses rx packets, forwards payload,
// checks the checksum and answers with ACK/ERR replies.
module ti_link_responder
   import ti_link_pkg::*;
#(
   parameter logic [15:0] c_MAXLEN   = 16'd1024,
   parameter logic [7:0]  c_REPLYMID = 8'h23,
   parameter logic [23:0] c_TIMEOUT  = 24'd4000000
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_avail,
   input  logic [7:0]  i_data,
   output logic        o_read,
   output logic [7:0]  o_txdata,
   output logic        o_txenable,
   input  logic        i_txbusy,
   output logic        o_pvalid,
   output logic [7:0]  o_pdata,
   output logic [7:0]  o_mid,
   output logic [7:0]  o_cmd,
   output logic [15:0] o_len,
   output logic        o_done,
   output logic        o_err,
   output logic        o_abort,
   output logic        o_busy
);

   state_t      state, state_nxt;
   logic [15:0] cnt, acc;
   logic [7:0]  ck_lo;
   logic [23:0] tcnt;
   logic        reply_start, reply_err, reply_done;
   logic        rx_take, counting, tc_hit, oversize;
   logic        pvalid_nxt, done_nxt, err_nxt, start_nxt, rerr_nxt;

   // Bytes are not taken while replying; a byte arrival beats the timeout.
   assign rx_take  = i_avail && !o_read && (state != S_REPLY);
   assign counting = (state != S_MID) && (state != S_REPLY);
   assign tc_hit   = counting && !rx_take && (tcnt == c_TIMEOUT - 24'd1);
   assign oversize = (o_len > c_MAXLEN);
   assign o_busy   = (state != S_MID);

   // Packet parser next state and one-cycle event decode.
   always_comb begin
      state_nxt  = state;
      pvalid_nxt = 1'b0;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      start_nxt  = 1'b0;
      rerr_nxt   = 1'b0;
      if (tc_hit) begin
         state_nxt = S_MID;
      end else if (rx_take) begin
         case (state)
            S_MID:  state_nxt = S_CMD;
            S_CMD:  state_nxt = S_LEN0;
            S_LEN0: state_nxt = S_LEN1;
            S_LEN1: begin
               if (has_data(o_cmd)) begin
                  state_nxt = ({i_data, o_len[7:0]} == 16'd0) ? S_CK0 : S_DATA;
               end else begin
                  done_nxt = 1'b1;
                  if (o_cmd == CMD_ACK || o_cmd == CMD_ERR) begin
                     state_nxt = S_MID;
                  end else begin
                     state_nxt = S_REPLY;
                     start_nxt = 1'b1;
                  end
               end
            end
            S_DATA: begin
               pvalid_nxt = !oversize;
               if (cnt + 16'd1 == o_len) state_nxt = S_CK0;
            end
            S_CK0:  state_nxt = S_CK1;
            S_CK1: begin
               if (({i_data, ck_lo} == acc) && !oversize) done_nxt = 1'b1;
               else                                       err_nxt  = 1'b1;
               rerr_nxt  = !(({i_data, ck_lo} == acc) && !oversize);
               start_nxt = 1'b1;
               state_nxt = S_REPLY;
            end
            default: ;
         endcase
      end else if (state == S_REPLY && reply_done) begin
         state_nxt = S_MID;
      end
   end

   // Parser state, rx handshake, header fields, payload and checksum datapath.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= S_MID;
         o_read      <= 1'b0;
         o_pvalid    <= 1'b0;
         o_pdata     <= 8'h00;
         o_mid       <= 8'h00;
         o_cmd       <= 8'h00;
         o_len       <= 16'h0000;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
         o_abort     <= 1'b0;
         cnt         <= 16'h0000;
         acc         <= 16'h0000;
         ck_lo       <= 8'h00;
         tcnt        <= 24'd0;
         reply_start <= 1'b0;
         reply_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         o_pvalid    <= pvalid_nxt;
         o_done      <= done_nxt;
         o_err       <= err_nxt;
         o_abort     <= tc_hit;
         reply_start <= start_nxt;
         if (start_nxt) reply_err <= rerr_nxt;

         if (rx_take)       o_read <= 1'b1;
         else if (!i_avail) o_read <= 1'b0;

         if (rx_take || tc_hit || !counting) tcnt <= 24'd0;
         else                                tcnt <= tcnt + 24'd1;

         if (tc_hit) acc <= 16'h0000;

         if (rx_take) begin
            case (state)
               S_MID: begin
                  o_mid <= i_data;
                  acc   <= 16'h0000;
                  cnt   <= 16'h0000;
               end
               S_CMD:  o_cmd <= i_data;
               S_LEN0: o_len <= {8'h00, i_data};
               S_LEN1: o_len[15:8] <= i_data;
               S_DATA: begin
                  o_pdata <= i_data;
                  acc     <= acc + {8'h00, i_data};
                  cnt     <= cnt + 16'd1;
               end
               S_CK0:  ck_lo <= i_data;
               default: ;
            endcase
         end
      end
   end

   ti_reply_sender #(.c_REPLYMID(c_REPLYMID)) u_reply (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .i_start    (reply_start),
      .i_is_err   (reply_err),
      .i_txbusy   (i_txbusy),
      .o_txdata   (o_txdata),
      .o_txenable (o_txenable),
      .o_done     (reply_done)
   );

endmodule

// File: tb/tb_ti_link_responder.sv
// Randomized bench for ti_link_responder with a packet-level reference model.
module tb_ti_link_responder;

   localparam logic [15:0] MAXLEN  = 16'd1024;
   localparam logic [7:0]  RMID    = 8'h23;
   localparam logic [23:0] TIMEOUT = 24'd8;

   logic        clk = 1'b0;
   logic        i_reset_n, i_avail, i_txbusy;
   logic [7:0]  i_data;
   logic        o_read, o_txenable, o_pvalid, o_done, o_err, o_abort, o_busy;
   logic [7:0]  o_txdata, o_pdata, o_mid, o_cmd;
   logic [15:0] o_len;

   int n_chk = 0, n_fail = 0;
   int tx_seen = 0, tx_lat = 1, tx_busy_len = 2;
   logic [7:0] q_pay[$], q_ev[$], q_tx[$], pkt[$];

   always #5 clk = ~clk;

   ti_link_responder #(.c_MAXLEN(MAXLEN), .c_REPLYMID(RMID), .c_TIMEOUT(TIMEOUT)) dut (
      .i_clock(clk), .i_reset_n(i_reset_n), .i_avail(i_avail), .i_data(i_data),
      .o_read(o_read), .o_txdata(o_txdata), .o_txenable(o_txenable), .i_txbusy(i_txbusy),
      .o_pvalid(o_pvalid), .o_pdata(o_pdata), .o_mid(o_mid), .o_cmd(o_cmd), .o_len(o_len),
      .o_done(o_done), .o_err(o_err), .o_abort(o_abort), .o_busy(o_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic logic has_data_m(input logic [7:0] c);
      return c inside {8'h06, 8'h15, 8'h36, 8'h88, 8'hA2, 8'hC9};
   endfunction

   function automatic logic [15:0] csum();
      int s = 0;
      foreach (pkt[i]) s += int'(pkt[i]);
      return 16'(s % 65536);
   endfunction

   // Payload and completion events, checked every cycle out of reset.
   always @(negedge clk) begin
      if (i_reset_n) begin
         if (o_pvalid) begin
            if (q_pay.size() == 0) chk("unexpected_pvalid", 32'(o_pdata), 32'hFFFF);
            else                   chk("pdata", 32'(o_pdata), 32'(q_pay.pop_front()));
         end
         if (int'(o_done) + int'(o_err) + int'(o_abort) > 1)
            chk("event_overlap", {o_done, o_err, o_abort}, 32'd0);
         else if (o_done || o_err || o_abort) begin
            logic [7:0] code;
            code = o_done ? "D" : (o_err ? "E" : "A");
            if (q_ev.size() == 0) chk("unexpected_event", 32'(code), 32'd0);
            else                  chk("event", 32'(code), 32'(q_ev.pop_front()));
         end
      end
   end

   // Transmitter model: checks each requested byte, then busy handshake.
   initial begin
      i_txbusy = 1'b0;
      forever begin
         @(negedge clk);
         if (o_txenable && i_reset_n) begin
            tx_seen++;
            if (q_tx.size() == 0) chk("unexpected_tx", 32'(o_txdata), 32'hFFFF);
            else                  chk("txdata", 32'(o_txdata), 32'(q_tx.pop_front()));
            repeat (tx_lat) @(negedge clk);
            i_txbusy = 1'b1;
            for (int k = 0; k < 200 && o_txenable; k++) @(negedge clk);
            if (o_txenable) chk("txenable_drop", 32'(o_txenable), 32'd0);
            repeat (tx_busy_len) @(negedge clk);
            i_txbusy = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int k;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      i_data  = b;
      i_avail = 1'b1;
      for (k = 0; k < 100 && !o_read; k++) @(negedge clk);
      if (!o_read) chk("read_timeout", 32'(o_read), 32'd1);
      i_avail = 1'b0;
      for (k = 0; k < 100 && o_read; k++) @(negedge clk);
      if (o_read) chk("read_release", 32'(o_read), 32'd0);
   endtask

   // Packet-level model: expectations come from the protocol rules, then the bytes are sent.
   task automatic run_packet(input logic [7:0] mid, input logic [7:0] cmd,
                             input logic [15:0] len, input logic [15:0] ck,
                             input bit wait_end);
      logic ok;
      if (has_data_m(cmd)) begin
         if (len <= MAXLEN) foreach (pkt[i]) q_pay.push_back(pkt[i]);
         ok = (csum() == ck) && (len <= MAXLEN);
         q_ev.push_back(ok ? "D" : "E");
         q_tx.push_back(RMID); q_tx.push_back(ok ? 8'h56 : 8'h5A);
         q_tx.push_back(8'h00); q_tx.push_back(8'h00);
      end else begin
         q_ev.push_back("D");
         if (cmd != 8'h56 && cmd != 8'h5A) begin
            q_tx.push_back(RMID); q_tx.push_back(8'h56);
            q_tx.push_back(8'h00); q_tx.push_back(8'h00);
         end
      end
      send_byte(mid); send_byte(cmd); send_byte(len[7:0]); send_byte(len[15:8]);
      if (has_data_m(cmd)) begin
         foreach (pkt[i]) send_byte(pkt[i]);
         send_byte(ck[7:0]); send_byte(ck[15:8]);
      end
      if (wait_end) begin
         int k;
         for (k = 0; k < 3000 && (q_ev.size() != 0 || q_tx.size() != 0 || o_busy); k++)
            @(negedge clk);
         chk("packet_complete", {q_ev.size() != 0, q_tx.size() != 0, o_busy}, 32'd0);
         chk("o_mid", 32'(o_mid), 32'(mid));
         chk("o_cmd", 32'(o_cmd), 32'(cmd));
         chk("o_len", 32'(o_len), 32'(len));
      end
   endtask

   initial begin
      int base;
      logic [7:0] cmds[11];
      logic [7:0] c;
      logic [15:0] l, ck;
      cmds = '{8'h06, 8'h15, 8'h36, 8'h88, 8'hA2, 8'hC9, 8'h09, 8'h68, 8'h56, 8'h5A, 8'h2D};
      i_reset_n = 1'b0; i_avail = 1'b0; i_data = 8'h00;

      // Hand-computed pins on the model itself.
      pkt = '{8'h01, 8'h02, 8'h03};
      chk("model_csum", 32'(csum()), 32'h0006);
      pkt = {};
      repeat (300) pkt.push_back(8'hFF);
      chk("model_csum_wrap", 32'(csum()), 32'h2AD4);
      chk("model_hasdata_cts", 32'(has_data_m(8'h09)), 32'd0);

      repeat (3) @(negedge clk);
      chk("reset_outs", {o_read, o_txenable, o_pvalid, o_done, o_err, o_abort, o_busy}, 32'd0);
      chk("reset_bytes", {o_txdata, o_pdata, o_mid, o_cmd}, 32'd0);
      chk("reset_len", 32'(o_len), 32'd0);
      i_reset_n = 1'b1;
      @(negedge clk);

      // Directed packets.
      pkt = '{8'h01, 8'h02, 8'h03};
      run_packet(8'h23, 8'hC9, 16'd3, 16'h0006, 1'b1);
      run_packet(8'h23, 8'hC9, 16'd3, 16'h0007, 1'b1);
      pkt = {};
      run_packet(8'h23, 8'h09, 16'd0, 16'h0000, 1'b1);
      base = tx_seen;
      run_packet(8'h23, 8'h56, 16'd0, 16'h0000, 1'b1);
      repeat (10) @(negedge clk);
      chk("ack_cmd_no_tx", 32'(tx_seen - base), 32'd0);
      run_packet(8'h73, 8'h06, 16'd0, 16'h0000, 1'b1);

      // Oversize: consumed, not forwarded, rejected.
      pkt = {};
      for (int i = 0; i < 1025; i++) pkt.push_back(8'($urandom));
      run_packet(8'h23, 8'h15, 16'h0401, csum(), 1'b1);

      // Inter-byte timeout.
      q_ev.push_back("A");
      send_byte(8'h23); send_byte(8'hC9);
      repeat (12) @(negedge clk);
      chk("abort_seen", 32'(q_ev.size()), 32'd0);
      chk("abort_idle", 32'(o_busy), 32'd0);
      pkt = '{8'h10, 8'h20};
      run_packet(8'h23, 8'hC9, 16'd2, 16'h0030, 1'b1);

      // Slow transmitter: exactly four requests per reply.
      tx_busy_len = 20; tx_lat = 2;
      base = tx_seen;
      pkt = '{8'hAA};
      run_packet(8'h23, 8'hA2, 16'd1, 16'h00AA, 1'b1);
      chk("slow_tx_count", 32'(tx_seen - base), 32'd4);

      // Reset during the second reply byte.
      tx_lat = 3;
      base = tx_seen;
      pkt = '{8'h05};
      run_packet(8'h23, 8'h88, 16'd1, 16'h0005, 1'b0);
      for (int k = 0; k < 500 && tx_seen < base + 2; k++) @(negedge clk);
      chk("second_byte_reached", 32'(tx_seen - base), 32'd2);
      #2 i_reset_n = 1'b0;
      #1 chk("reset_txenable", 32'(o_txenable), 32'd0);
      chk("reset_state_idle", 32'(o_busy), 32'd0);
      q_tx = {}; q_ev = {}; q_pay = {};
      repeat (3) @(negedge clk);
      i_reset_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("reset_no_more_tx", 32'(tx_seen - base), 32'd2);

      // Randomized packets.
      for (int n = 0; n < 30; n++) begin
         tx_lat = $urandom_range(0, 3);
         tx_busy_len = $urandom_range(1, 4);
         c = cmds[$urandom_range(0, 10)];
         l = has_data_m(c) ? 16'($urandom_range(0, 12)) : 16'($urandom);
         pkt = {};
         if (has_data_m(c)) for (int i = 0; i < int'(l); i++) pkt.push_back(8'($urandom));
         ck = csum();
         if ($urandom_range(0, 3) == 0) ck = ck ^ 16'($urandom_range(1, 65535));
         run_packet(8'($urandom), c, l, ck, 1'b1);
      end

      chk("final_queues", {q_pay.size() != 0, q_ev.size() != 0, q_tx.size() != 0}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ti_link_responder.md
# ti_link_responder

Link-layer packet responder for the TI link protocol, on the receiving side of the dbus byte stream. It pulls bytes from the dbus receiver with the same avail/read four-phase handshake the bridge uses, and parses packets of the form machine ID, command, 16-bit length, optional data and 16-bit checksum. Payload bytes go to a local sink. ACK or ERR reply packets go back out through the dbus transmitter handshake, so the block can stand in for the PC end of a link session.

## Interface
Parameters:
- c_MAXLEN, 16'd1024: largest payload length forwarded; longer packets are consumed but rejected.
- c_REPLYMID, 8'h23: machine ID placed in byte 0 of every reply.
- c_TIMEOUT, 24'd4000000: inter-byte timeout in i_clock cycles (1 s at 4 MHz).

Ports:
- i_clock, in, 1: single clock; all logic on posedge.
- i_reset_n, in, 1: asynchronous, active-low reset.
- i_avail, in, 1: rx byte available (level).
- i_data, in, 8: rx byte; valid while i_avail is high.
- o_read, out, 1: rx byte taken (four-phase).
- o_txdata, out, 8: reply byte.
- o_txenable, out, 1: reply byte request (four-phase).
- i_txbusy, in, 1: transmitter busy.
- o_pvalid, out, 1: one-cycle strobe per forwarded payload byte.
- o_pdata, out, 8: payload byte; valid with o_pvalid.
- o_mid, out, 8: machine ID of the current or last packet.
- o_cmd, out, 8: command of the current or last packet.
- o_len, out, 16: length of the current or last packet.
- o_done, out, 1: one-cycle pulse when a packet completes with a good checksum.
- o_err, out, 1: one-cycle pulse on checksum error or oversize packet.
- o_abort, out, 1: one-cycle pulse on timeout.
- o_busy, out, 1: high whenever state is not S_MID.

## Operation
- Rx handshake: when i_avail=1 and o_read=0, latch i_data and set o_read. Hold o_read until i_avail=0, then clear it. Only one byte is taken per read cycle.
- Tx handshake: when idle and i_txbusy=0, drive o_txdata and set o_txenable. Hold until i_txbusy=1, then clear. The next byte waits for i_txbusy=0.
- States and transitions:
  - S_MID: latch o_mid.
  - S_CMD: latch o_cmd.
  - S_LEN0 then S_LEN1: length, little-endian.
  - After S_LEN1: go to S_DATA if the command has data, otherwise to S_REPLY or back to S_MID.
  - S_DATA: length bytes.
  - S_CK0 then S_CK1: checksum, little-endian.
  - S_REPLY: sends 4 bytes.
- Data commands: 0x06 VAR, 0x15 XDP, 0x36 SKE, 0x88 DEL, 0xA2 REQ, 0xC9 RTS.
- Data command with length 0: go straight to S_CK0. The expected checksum is 0.
- Checksum: 16-bit sum of the data bytes, modulo 2^16, with wrap-around.
- Packet with data: on a checksum match with length ≤ c_MAXLEN, pulse o_done and reply ACK. On a mismatch or oversize, pulse o_err and reply ERR.
- Packet without data: pulse o_done. Reply ACK unless the command is 0x56 ACK or 0x5A ERR; for those, return to S_MID with no reply.
- Reply bytes: ACK = c_REPLYMID, 0x56, 0x00, 0x00. ERR = c_REPLYMID, 0x5A, 0x00, 0x00.
- Oversize packets: data is consumed and counted, but o_pvalid is suppressed.
- Forwarding: o_pvalid pulses in the cycle the byte is latched. There is no backpressure on the payload path.
- Timeout: a counter clears on every accepted byte and counts while state is not S_MID or S_REPLY. At c_TIMEOUT it pulses o_abort, clears the accumulator and returns to S_MID. No reply is sent.
- S_REPLY: no rx bytes are accepted, so o_read stays 0 and i_avail is left pending.

## Timing
- Reset values: every output is 0. State is S_MID, counters and accumulator are 0.
- Reset mid-operation: takes effect immediately. A partial packet or reply is discarded, o_read and o_txenable drop, and no reply is sent.
- Payload latency: o_pvalid and o_pdata appear 1 cycle after the i_avail rising edge is sampled.
- Completion: o_done or o_err pulses in the cycle the CK1 byte is latched.
- Reply start: o_txenable rises no earlier than the cycle after that.
- Return to idle: S_MID is re-entered the cycle after the 4th reply byte's i_txbusy rises.
- Length counter: 16-bit, compared against o_len. Length 0xFFFF is legal and is handled as oversize.
- Simultaneous events: timeout terminal count in the same cycle as a byte arrival means the byte wins and the counter clears.

## Structure
- Package ti_link_pkg:
  - command constants: CMD_VAR, CMD_XDP, CMD_SKE, CMD_DEL, CMD_REQ, CMD_RTS, CMD_ACK, CMD_ERR;
  - the state encoding;
  - function has_data(cmd).
- Sub-module ti_reply_sender: a 4-byte tx handshake sequencer. Inputs are start and is_err; output is done.

## Test plan
- Packet 23 C9 03 00 01 02 03 06 00 → o_pvalid ×3 with 01, 02, 03; o_done; reply 23 56 00 00.
- Same packet with checksum 07 00 → o_err, no o_done, reply 23 5A 00 00.
- Header 23 09 00 00 (CTS) → o_done, ACK reply. Header 23 56 00 00 → o_done, no tx activity.
- Length 0x0401 with c_MAXLEN=1024 → 1025 bytes consumed, zero o_pvalid, o_err, ERR reply.
- Stall 10 cycles after 23 C9 with c_TIMEOUT=8 → o_abort; next full packet parses normally.
- Assert i_reset_n=0 during the 2nd reply byte → o_txenable=0 at once, state S_MID, no further tx. Slow i_txbusy (20-cycle busy per byte) → exactly 4 enables.
